medidor_frecuencia: RTL
=======================

Name: medidor_frecuencia

Overview:
- Frequency meter for a slow external or derived square wave, such as a prescaled tick or a board input.
- Counts rising edges of `sig_in` over a fixed gate window of `GATE_CYCLES` `clk` cycles, then publishes the count. With the default parameters the gate is 1 s, so `freq` reads directly in Hz.
- Supports single-shot and continuous measurement. Sits beside the clock-division logic as the measuring end of the slow-clock path.

Parameters:
- `GATE_CYCLES`, 50000000, gate window length in `clk` cycles (1 s at 50 MHz); must be ≥ 2.
- `GW`, 26, width of the gate counter; must satisfy 2^GW > `GATE_CYCLES`.
- `CNT_W`, 26, width of the edge counter and of `freq`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `sig_in`  in  1  signal to measure; asynchronous to `clk`.
- `start`  in  1  request a single measurement; level-sampled in IDLE only.
- `cont`  in  1  continuous mode: 1 = restart a measurement automatically after every result.
- `busy`  out  1  high while in MEASURE or DONE.
- `valid`  out  1  one-cycle pulse, high when `freq`/`overflow` update.
- `freq`  out  CNT_W  rising-edge count of the last completed window.
- `overflow`  out  1  last completed window saturated the edge counter.

Behaviour:
- Reset (synchronous, `rst`=1 at a `clk` edge):
  - state=IDLE; gate counter=0; edge counter=0.
  - Sync flops and edge-detect register = 0.
  - Outputs: `busy`=0, `valid`=0, `freq`=0, `overflow`=0.
  - Reset mid-measurement discards the window with no `valid` pulse.
- Input conditioning:
  - `sig_in` passes through a 2-flop synchronizer, then a third register for edge detection.
  - `rise` = s2 & ~s3. A physical edge yields `rise` 3 cycles later.
  - `sig_in` high and low times must each be ≥ 2 `clk` cycles; faster inputs are out of spec.
- States: IDLE, MEASURE, DONE.
- IDLE:
  - `busy`=0.
  - If `start`=1 or `cont`=1: clear gate counter and edge counter, go to MEASURE.
- MEASURE:
  - Lasts exactly `GATE_CYCLES` cycles; the gate counter runs 0 .. `GATE_CYCLES`-1.
  - Each cycle with `rise`=1 increments the edge counter.
  - The edge counter saturates at 2^CNT_W-1. A `rise` while saturated sets an internal ovf bit.
  - On the cycle where the gate counter = `GATE_CYCLES`-1: the `rise` of that cycle is still counted, then go to DONE.
  - `start` is ignored.
- DONE (exactly 1 cycle):
  - `freq` <= final edge count, `overflow` <= ovf, `valid`=1.
  - A `rise` in this cycle is not counted in any window.
  - If `cont`=1: clear counters and ovf, go directly to MEASURE. Windows are then back-to-back with a 1-cycle gap, period `GATE_CYCLES`+1.
  - Else go to IDLE.
- Timing:
  - `start` sampled high in IDLE at edge t → MEASURE cycles t+1 .. t+`GATE_CYCLES`.
  - `valid` high during cycle t+`GATE_CYCLES`+1.
  - `freq` updates at the same edge as `valid` rises.
- Output holding:
  - `freq` and `overflow` hold their values between `valid` pulses and are never cleared except by `rst`.
  - `valid` is registered, never combinational.
- `cont` dropped during MEASURE: the current window completes normally, then the block returns to IDLE.
- `start` and `cont` both high in IDLE: same as `start` alone, then continuous behaviour applies.

Test Plan:
1. `GATE_CYCLES`=100, `sig_in` period 10 clk (5 high/5 low), pulse `start` once → single `valid` 101 cycles after the start edge; `freq`=10, `overflow`=0; `busy` returns to 0.
2. `GATE_CYCLES`=100, `sig_in` held 0, `start` → `freq`=0, `valid` pulses once; then `sig_in` period 4 with `cont`=1 → `valid` every 101 cycles with `freq`=25 from the second window onward (first window after the change may read 24–25).
3. `GATE_CYCLES`=100, `CNT_W`=3, `sig_in` period 4 → `freq`=7, `overflow`=1; next window with `sig_in`=0 → `freq`=0, `overflow`=0.
4. Assert `rst` at gate count 50 during MEASURE → no `valid`; `freq`=0, `busy`=0 the next cycle; a new `start` then gives a correct result.
5. `start` pulsed repeatedly during MEASURE → exactly one `valid`, window length unchanged (101-cycle latency from the first accepted `start`).
6. Default parameters, `sig_in` = 1 kHz from a divided clock, `cont`=1 → `freq`=1000 each window; `valid` spacing 50000001 cycles.

Source files
------------

// File: rtl/medidor_frecuencia.sv
// medidor_frecuencia: gated frequency meter for slow square waves.
//
// Counts rising edges of sig_in over a window of GATE_CYCLES clk cycles and
// publishes the count on freq with a one-cycle valid pulse. With the default
// parameters the window is 1 s at 50 MHz, so freq reads directly in Hz.
//
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high
//   sig_in   signal to measure, asynchronous to clk
//   start    request one measurement (sampled in idle only)
//   cont     continuous mode: restart automatically after every result
//   busy     high while measuring or publishing
//   valid    one-cycle pulse when freq/overflow update
//   freq     rising-edge count of the last completed window
//   overflow last completed window saturated the edge counter
module medidor_frecuencia #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned GW          = 26,
  parameter int unsigned CNT_W       = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] freq,
  output logic             overflow
);

  typedef enum logic [1:0] {StIdle, StMeasure, StDone} state_e;

  localparam logic [GW-1:0]    GateLast = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  state_e           state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             ovf;

  // Two-flop synchronizer plus one delay stage for edge detection.
  logic s1, s2, s3;
  logic rise;

  logic             cnt_sat;
  logic             cnt_inc;
  logic             ovf_hit;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  always_comb begin
    rise     = s2 & ~s3;
    cnt_sat  = (edge_cnt == CntMax);
    cnt_inc  = rise & ~cnt_sat;
    ovf_hit  = rise & cnt_sat;
    cnt_next = edge_cnt + CNT_W'(cnt_inc);
    ovf_next = ovf | ovf_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      freq     <= '0;
      overflow <= 1'b0;
    end else begin
      s1    <= sig_in;
      s2    <= s1;
      s3    <= s2;
      valid <= 1'b0;

      case (state)
        StIdle: begin
          if (start || cont) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
            busy     <= 1'b1;
            state    <= StMeasure;
          end
        end

        StMeasure: begin
          edge_cnt <= cnt_next;
          ovf      <= ovf_next;
          if (gate_cnt == GateLast) begin
            // The last gate cycle's rise is included in the published count.
            freq     <= cnt_next;
            overflow <= ovf_next;
            valid    <= 1'b1;
            state    <= StDone;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
          end
        end

        StDone: begin
          // A rise seen here belongs to no window: counters are cleared below.
          if (cont) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
            state    <= StMeasure;
          end else begin
            busy  <= 1'b0;
            state <= StIdle;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
